// File: rtl/sim_lat_mem.sv
// sim_lat_mem: simulation memory model with one request/response port, a fixed
// request-to-response latency and several outstanding requests returned in order.
// The backing store is a word array accessed through verilog_pmem_read /
// verilog_pmem_write-style helpers at the accepting edge.
// Optional build macro SIM_MEM_STALL_EN adds LFSR-driven pseudo-random backpressure
// on req_ready.
module sim_lat_mem #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MEM_WORDS = 4096
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_mask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_write
);

  localparam int unsigned NWORDS = DATA_W / 32;
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ENT_W  = DATA_W + 1;

  logic [31:0]       mem_q [MEM_WORDS];
  logic [IDX_W-1:0]  base_idx;
  logic [DATA_W-1:0] rd_data;
  logic              accept;
  logic              pop;
  logic              ready_base;
  logic              push_valid;
  logic [ENT_W-1:0]  push_ent;
  logic [ENT_W-1:0]  pipe_in_ent;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ENT_W-1:0]  fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic [ENT_W-1:0]  head_ent;

  // Address bits below the word and above the array index play no part in the lookup.
  logic unused_addr;
  assign unused_addr = ^{req_addr[1:0], req_addr[ADDR_W-1:IDX_W+2]};

  // Word index of the first 32-bit word of the aligned access.
  assign base_idx = req_addr[IDX_W+1:2] & ~IDX_W'(NWORDS - 1);

  assign accept = req_valid && req_ready;
  assign pop    = resp_valid && resp_ready;

  // verilog_pmem_read equivalent: gather one 32-bit word per lane.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(NWORDS); i++) begin
      rd_data[32*i +: 32] = mem_q[base_idx | IDX_W'(i)];
    end
  end

  // verilog_pmem_write equivalent: byte-masked store at accept; empty lanes are no-ops.
  always_ff @(posedge clock) begin
    if (accept && req_write) begin
      for (int i = 0; i < int'(NWORDS); i++) begin
        for (int b = 0; b < 4; b++) begin
          if (req_mask[4*i + b]) begin
            mem_q[base_idx | IDX_W'(i)][8*b +: 8] <= req_wdata[32*i + 8*b +: 8];
          end
        end
      end
    end
  end

  // Write responses carry zero data; reads carry the data seen at accept.
  assign pipe_in_ent = {req_write, req_write ? {DATA_W{1'b0}} : rd_data};

  if (LATENCY == 1) begin : g_lat1
    assign push_valid = accept;
    assign push_ent   = pipe_in_ent;
  end else begin : g_pipe
    logic [LATENCY-2:0] vld_q;
    logic [ENT_W-1:0]   ent_q [LATENCY-1];

    // Delay line: the last stage feeds the response FIFO one edge later.
    always_ff @(posedge clock) begin
      if (!reset) begin
        vld_q <= '0;
        for (int i = 0; i < int'(LATENCY) - 1; i++) begin
          ent_q[i] <= '0;
        end
      end else begin
        vld_q[0] <= accept;
        ent_q[0] <= pipe_in_ent;
        for (int i = 1; i < int'(LATENCY) - 1; i++) begin
          vld_q[i] <= vld_q[i-1];
          ent_q[i] <= ent_q[i-1];
        end
      end
    end

    assign push_valid = vld_q[LATENCY-2];
    assign push_ent   = ent_q[LATENCY-2];
  end

  // Next-state for outstanding counter and FIFO pointers.
  always_comb begin
    cnt_d    = cnt_q;
    fcnt_d   = fcnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    unique case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    unique case ({push_valid, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
    if (push_valid) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  // Counter, pointers and FIFO storage; reset discards everything in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q    <= '0;
      fcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_valid) begin
        fifo_q[wr_ptr_q] <= push_ent;
      end
    end
  end

  assign ready_base = reset && (cnt_q < CNT_W'(DEPTH));

`ifdef SIM_MEM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR state, reseeded on reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign req_ready = ready_base && (lfsr_q[1:0] != 2'b00);
`else
  assign req_ready = ready_base;
`endif

  assign resp_valid = (fcnt_q != '0);
  assign head_ent   = resp_valid ? fifo_q[rd_ptr_q] : '0;
  assign resp_write = head_ent[DATA_W];
  assign resp_rdata = head_ent[DATA_W-1:0];

endmodule

// File: tb/tb_sim_lat_mem.sv
// Scoreboard bench for sim_lat_mem (DATA_W=64, LATENCY=3, DEPTH=4).
module tb_sim_lat_mem;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned LATENCY = 3;
  localparam int unsigned DEPTH   = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [7:0]        req_mask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_write;

  sim_lat_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LATENCY(LATENCY),
    .DEPTH  (DEPTH)
  ) u_dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_mask  (req_mask),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_write(resp_write)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [63:0] data;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic in_rst  = 1'b0;
  logic head_seen = 1'b0;
  int   last_pop  = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) begin
    cyc    <= cyc + 1;
    in_rst <= !reset;
  end

  // Monitor: compares the FIFO head against the scoreboard every cycle it is shown.
  always @(negedge clock) begin
    int exp_cyc;
    if (!reset) begin
      sb_q.delete();
      head_seen = 1'b0;
      last_pop  = -1;
      if (in_rst) begin
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_write", 64'(resp_write), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
      end
    end else if (resp_valid) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL stale_resp: resp_valid=1 rdata %h, expected no response", resp_rdata);
      end else begin
        if (!head_seen) begin
          exp_cyc = sb_q[0].acc + int'(LATENCY) - 1;
          if (last_pop + 1 > exp_cyc) exp_cyc = last_pop + 1;
          chk("resp_latency", 64'(cyc), 64'(exp_cyc));
          head_seen = 1'b1;
        end
        chk("resp_write", 64'(resp_write), 64'(sb_q[0].wr));
        chk("resp_rdata", resp_rdata, sb_q[0].data);
        if (resp_ready) begin
          void'(sb_q.pop_front());
          head_seen = 1'b0;
          last_pop  = cyc;
        end
      end
    end
  end

  // Drive one request from posedge+1; returns the accepting edge and cycles stalled.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [63:0] wd,
                       input logic [7:0] m, input logic [63:0] exp_rd,
                       output int acc_edge, output int waited);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_mask  = m;
    waited    = 0;
    while (!req_ready && waited < 50) begin
      @(posedge clock);
      #1;
      waited++;
    end
    if (!req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: req_ready=0 after %0d cycles, expected 1", waited);
      req_valid = 1'b0;
      acc_edge  = -1;
    end else begin
      sb_q.push_back('{wr, wr ? 64'd0 : exp_rd, cyc + 1});
      acc_edge = cyc + 1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("drain_pending", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int acc, w, acc_prev, c0;
    logic [31:0] addrs [4];
    logic [63:0] datas [4];
    addrs[0] = 32'h8000_0020; datas[0] = 64'h1111_0001_2222_0002;
    addrs[1] = 32'h8000_0028; datas[1] = 64'h3333_0003_4444_0004;
    addrs[2] = 32'h8000_0030; datas[2] = 64'h5555_0005_6666_0006;
    addrs[3] = 32'h8000_0038; datas[3] = 64'h7777_0007_8888_0008;

    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_mask   = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("ready_in_reset", 64'(req_ready), 64'd0);
    reset = 1'b1;
    #1;
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    // Write then read back-to-back, same address.
    issue(1'b1, 32'h8000_0000, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF, 64'd0, acc_prev, w);
    issue(1'b0, 32'h8000_0000, 64'd0, 8'h00, 64'hCAFE_F00D_DEAD_BEEF, acc, w);
    chk("raw_back_to_back", 64'(acc), 64'(acc_prev + 1));

    // Masked writes on a 64-bit word pair.
    issue(1'b1, 32'h8000_0010, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 64'd0, acc, w);
    issue(1'b1, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'h0F, 64'd0, acc, w);
    issue(1'b0, 32'h8000_0010, 64'd0, 8'h00, 64'hAAAA_BBBB_5566_7788, acc, w);
    issue(1'b1, 32'h8000_0010, 64'h0000_1234_0000_0000, 8'h30, 64'd0, acc, w);
    issue(1'b0, 32'h8000_0017, 64'd0, 8'h00, 64'hAAAA_1234_5566_7788, acc, w);
    issue(1'b1, 32'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0, acc, w);
    issue(1'b0, 32'h8000_0010, 64'd0, 8'h00, 64'hAAAA_1234_5566_7788, acc, w);
    wait_idle();

    // Fill to DEPTH with responses held back, then release one.
    for (int i = 0; i < 4; i++) issue(1'b1, addrs[i], datas[i], 8'hFF, 64'd0, acc, w);
    wait_idle();
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0, addrs[i], 64'd0, 8'h00, datas[i], acc, w);
    chk("full_ready_low", 64'(req_ready), 64'd0);
    repeat (4) @(posedge clock);
    #1;
    chk("full_ready_held", 64'(req_ready), 64'd0);
    chk("full_resp_valid", 64'(resp_valid), 64'd1);
    resp_ready = 1'b1;
    c0 = cyc;
    issue(1'b0, addrs[0], 64'd0, 8'h00, datas[0], acc, w);
    chk("fifth_accept_edge", 64'(acc), 64'(c0 + 2));
    wait_idle();

    // Streaming: accept and response handshake together every cycle.
    acc_prev = -1;
    for (int i = 0; i < 14; i++) begin
      issue(1'b0, addrs[i % 4], 64'd0, 8'h00, datas[i % 4], acc, w);
      if (i > 0) chk("stream_consecutive", 64'(acc), 64'(acc_prev + 1));
      acc_prev = acc;
    end
    wait_idle();

    // Reset with three reads outstanding.
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, addrs[i], 64'd0, 8'h00, datas[i], acc, w);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    chk("no_stale_after_reset", 64'(resp_valid), 64'd0);
    chk("ready_after_midreset", 64'(req_ready), 64'd1);
    resp_ready = 1'b1;
    issue(1'b0, 32'h8000_0010, 64'd0, 8'h00, 64'hAAAA_1234_5566_7788, acc, w);
    issue(1'b0, addrs[3], 64'd0, 8'h00, datas[3], acc, w);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
